// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised register file for the single-cycle processor datapath. It has
// one write port, two registered read ports and a hardware bulk-clear
// sequencer. Addresses come from the instruction decoder, OUT1/OUT2 feed the
// ALU, and the ALU result returns on IN.
//
// Parameters
//   DATA_W       register width in bits
//   ADDR_W       address width; DEPTH = 2**ADDR_W registers
//
// Ports
//   clk          system clock, all state changes on posedge
//   RESET        asynchronous, active-high reset
//   IN           write data
//   INaddr       write address
//   WRITE        write enable, sampled at posedge (ignored while clearing)
//   OUT1addr     read port 1 address
//   OUT2addr     read port 2 address
//   OUT1         registered read data, port 1 (1-cycle latency)
//   OUT2         registered read data, port 2 (1-cycle latency)
//   CLEAR        start bulk clear, sampled at posedge (ignored while clearing)
//   BUSY         high while the clear sequencer runs
//   state_dbg_o  current sequencer state (0 = IDLE, 1 = CLEARING)
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a port-write issued in IDLE to the same
//                      address a read port is reading is forwarded to that
//                      read port on the same edge. Clear-sweep writes are
//                      never forwarded. When undefined, reads always return
//                      the pre-edge array contents.
//
// Handshake: there is no valid/ready pair. Every posedge captures one read per
// port; WRITE and CLEAR are single-cycle strobes sampled at posedge and are
// acted on only in IDLE, otherwise they are dropped (never queued).
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INaddr,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1addr,
    input  logic [ADDR_W-1:0] OUT2addr,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              state_dbg_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] regs_q [DEPTH];

    // Next read data for each port, before registering.
    logic [DATA_W-1:0] out1_d;
    logic [DATA_W-1:0] out2_d;

    always_comb begin
        out1_d = regs_q[OUT1addr];
        out2_d = regs_q[OUT2addr];
`ifdef REGFILE_BYPASS_EN
        // Only a real port write (accepted in IDLE) is forwarded.
        if (WRITE && (state_q == IDLE) && (INaddr == OUT1addr)) begin
            out1_d = IN;
        end
        if (WRITE && (state_q == IDLE) && (INaddr == OUT2addr)) begin
            out2_d = IN;
        end
`endif
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            // Each register resets to its own index, truncated to DATA_W.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
            state_q <= IDLE;
            cnt_q   <= '0;
            BUSY    <= 1'b0;
            OUT1    <= '0;
            OUT2    <= '0;
        end else begin
            OUT1 <= out1_d;
            OUT2 <= out2_d;
            case (state_q)
                IDLE: begin
                    // A write coinciding with CLEAR lands now and is zeroed
                    // later by the sweep.
                    if (WRITE) begin
                        regs_q[INaddr] <= IN;
                    end
                    if (CLEAR) begin
                        state_q <= CLEARING;
                        cnt_q   <= '0;
                        BUSY    <= 1'b1;
                    end
                end
                CLEARING: begin
                    regs_q[cnt_q] <= '0;
                    cnt_q         <= cnt_q + 1'b1;
                    // The state change, not the counter wrap, ends the sweep.
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
// Directed bench for reg_file_param. An 8x8 instance is driven cycle by cycle
// from a driver task that pushes the expected {OUT1, OUT2, BUSY} for each
// edge into exp_q; a monitor pops and compares on the following negedge.
// Reset-time values and a 16x16 instance are checked directly.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    localparam int W = 17;  // {OUT1, OUT2, BUSY}

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] IN = '0;
    logic [2:0] INaddr = '0;
    logic       WRITE = 1'b0;
    logic [2:0] OUT1addr = '0;
    logic [2:0] OUT2addr = '0;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       CLEAR = 1'b0;
    logic       BUSY;
    logic       state_dbg;

    logic [15:0] w_IN = '0;
    logic [3:0]  w_INaddr = '0;
    logic        w_WRITE = 1'b0;
    logic [3:0]  w_OUT1addr = '0;
    logic [3:0]  w_OUT2addr = '0;
    logic [15:0] w_OUT1;
    logic [15:0] w_OUT2;
    logic        w_BUSY;
    logic        w_state_dbg;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic         issue = 1'b0;
    logic         fire = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    reg_file_param #(.DATA_W(8), .ADDR_W(3)) u_dut (
        .clk(clk), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WRITE(WRITE),
        .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .OUT1(OUT1), .OUT2(OUT2),
        .CLEAR(CLEAR), .BUSY(BUSY), .state_dbg_o(state_dbg)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(4)) u_dut16 (
        .clk(clk), .RESET(RESET), .IN(w_IN), .INaddr(w_INaddr), .WRITE(w_WRITE),
        .OUT1addr(w_OUT1addr), .OUT2addr(w_OUT2addr), .OUT1(w_OUT1), .OUT2(w_OUT2),
        .CLEAR(1'b0), .BUSY(w_BUSY), .state_dbg_o(w_state_dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) fire <= issue;

    // Monitor: one expected entry per issued edge.
    always @(negedge clk) begin
        if (fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got output with no expectation");
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("out1", {24'd0, OUT1}, {24'd0, e[16:9]});
                check("out2", {24'd0, OUT2}, {24'd0, e[8:1]});
                check("busy", {31'd0, BUSY}, {31'd0, e[0]});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                        input logic clr, input logic [2:0] a1, input logic [2:0] a2,
                        input logic [7:0] e1, input logic [7:0] e2, input logic eb);
        @(negedge clk);
        WRITE    = wr;
        INaddr   = wa;
        IN       = wd;
        CLEAR    = clr;
        OUT1addr = a1;
        OUT2addr = a2;
        exp_q.push_back({e1, e2, eb});
        issue = 1'b1;
    endtask

    task automatic quiet();
        @(negedge clk);
        WRITE = 1'b0;
        CLEAR = 1'b0;
        issue = 1'b0;
    endtask

    logic [7:0] byp;

    initial begin
        // Reset values while RESET is held.
        #12;
        check("rst_out1", {24'd0, OUT1}, 32'h0);
        check("rst_out2", {24'd0, OUT2}, 32'h0);
        check("rst_busy", {31'd0, BUSY}, 32'h0);
        @(negedge clk);
        RESET = 1'b0;

        // Reads of reset contents.
        step(0, 0, 8'h00, 0, 3'd5, 3'd7, 8'h05, 8'h07, 0);
        step(0, 0, 8'h00, 0, 3'd0, 3'd1, 8'h00, 8'h01, 0);

        // Write with same-address read on both ports.
`ifdef REGFILE_BYPASS_EN
        byp = 8'hA5;
`else
        byp = 8'h03;
`endif
        step(1, 3'd3, 8'hA5, 0, 3'd3, 3'd3, byp, byp, 0);
        step(0, 0, 8'h00, 0, 3'd3, 3'd2, 8'hA5, 8'h02, 0);
`ifdef REGFILE_BYPASS_EN
        byp = 8'h3C;
`else
        byp = 8'h06;
`endif
        step(1, 3'd6, 8'h3C, 0, 3'd1, 3'd6, 8'h01, byp, 0);
        step(0, 0, 8'h00, 0, 3'd6, 3'd7, 8'h3C, 8'h07, 0);

        // Single-cycle CLEAR: BUSY for 8 cycles; write to reg 2 during the
        // sweep (after reg 2 is already zeroed) must be dropped.
        step(0, 0, 8'h00, 1, 3'd3, 3'd0, 8'hA5, 8'h00, 1);
        for (int k = 1; k <= 7; k++) begin
            step((k == 5), 3'd2, 8'hFF, 0, 3'd2, 3'd0, (k <= 3) ? 8'h02 : 8'h00, 8'h00, 1);
        end
        step(0, 0, 8'h00, 0, 3'd2, 3'd7, 8'h00, 8'h07, 0);
        step(0, 0, 8'h00, 0, 3'd7, 3'd2, 8'h00, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 8'h00, 0, 3'(i), 3'(7 - i), 8'h00, 8'h00, 0);
        end

        // CLEAR held for 20 cycles: sweeps of 8 separated by one IDLE edge.
        for (int n = 0; n <= 26; n++) begin
            step(0, 0, 8'h00, (n < 20), 3'd0, 3'd5, 8'h00, 8'h00, ((n % 9) != 8));
        end

        // WRITE together with CLEAR in IDLE: write lands, then is swept.
`ifdef REGFILE_BYPASS_EN
        byp = 8'h77;
`else
        byp = 8'h00;
`endif
        step(1, 3'd4, 8'h77, 1, 3'd4, 3'd4, byp, byp, 1);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 8'h00, 0, 3'd4, 3'd1, (k <= 5) ? 8'h77 : 8'h00, 8'h00, (k < 8));
        end
        step(0, 0, 8'h00, 0, 3'd4, 3'd4, 8'h00, 8'h00, 0);

        // RESET in the middle of a sweep.
        step(0, 0, 8'h00, 1, 3'd6, 3'd6, 8'h00, 8'h00, 1);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 8'h00, 0, 3'd6, 3'd6, 8'h00, 8'h00, 1);
        end
        quiet();
        @(negedge clk);
        check("pre_rst_busy", {31'd0, BUSY}, 32'h1);
        RESET = 1'b1;
        #1;
        check("midclr_busy", {31'd0, BUSY}, 32'h0);
        check("midclr_out1", {24'd0, OUT1}, 32'h0);
        check("midclr_out2", {24'd0, OUT2}, 32'h0);
        @(negedge clk);
        RESET = 1'b0;
        step(0, 0, 8'h00, 0, 3'd6, 3'd0, 8'h06, 8'h00, 0);
        step(0, 0, 8'h00, 0, 3'd1, 3'd2, 8'h01, 8'h02, 0);
        quiet();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        // 16-bit / 16-entry instance.
        w_OUT1addr = 4'd9;
        w_OUT2addr = 4'd15;
        @(negedge clk);
        check("w_rst_reg9", {16'd0, w_OUT1}, 32'h0009);
        check("w_rst_reg15", {16'd0, w_OUT2}, 32'h000F);
        w_WRITE  = 1'b1;
        w_INaddr = 4'd15;
        w_IN     = 16'hBEEF;
        w_OUT1addr = 4'd15;
        w_OUT2addr = 4'd15;
        @(negedge clk);
        w_WRITE = 1'b0;
        @(negedge clk);
        check("w_out1_beef", {16'd0, w_OUT1}, 32'hBEEF);
        check("w_out2_beef", {16'd0, w_OUT2}, 32'hBEEF);
        check("w_busy", {31'd0, w_BUSY}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
